// File: rtl/lsu_pkg.sv
// Shared LSU encodings: funct3 codes, FSM states, byte-strobe constants and
// small address/lane helpers used by the LSU datapath.
package lsu_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Illegal encodings collapse to LW/SW; after this op[1:0] is the access size.
  function automatic logic [2:0] norm_op(input logic [2:0] op, input logic we);
    case (op)
      LSU_B, LSU_H:   return op;
      LSU_BU, LSU_HU: return we ? LSU_W : op;
      default:        return LSU_W;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return STRB_B << off;
      2'b01:   return off[1] ? (STRB_H << 2) : STRB_H;
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half at the latched offset
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[off*8 +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (op)
      LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  data = {24'd0, byte_sel};
      LSU_H:   data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding valid/ready memory transaction, load
// alignment/extension to writeback. LSU_MISALIGN_TRAP_EN enables misalign traps.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [RD_WIDTH-1:0]   req_rd,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] misalign_addr
);

  lsu_state_e            state, state_nxt;
  logic [2:0]            op_q;
  logic [RD_WIDTH-1:0]   rd_q;
  logic [1:0]            off_q;
  logic                  kill_q;
  logic [DATA_WIDTH-1:0] ld_data;

  logic [2:0] op_n;
  logic [1:0] sz_n;
  logic       accept, go, rsp_fire;

  assign op_n     = norm_op(req_op, req_we);
  assign sz_n     = op_n[1:0];
  assign accept   = req_ready & req_valid;
  assign rsp_fire = (state == S_RESP) & mem_rsp_valid;

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign req_ready     = (state == S_IDLE) & rst_n;
  assign mem_req_valid = (state == S_REQ);

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_mis, trap;

  assign is_mis = ((sz_n == 2'b01) & req_addr[0]) | ((sz_n == 2'b10) & (req_addr[1:0] != 2'b00));
  assign trap   = accept & is_mis;
  assign go     = accept & ~is_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= trap;
      if (trap) misalign_addr <= req_addr;
    end
  end
`else
  assign go            = accept;
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go) state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = mem_we ? S_IDLE : S_RESP;
      S_RESP: if (mem_rsp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      off_q     <= '0;
      kill_q    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      if (go) begin
        op_q      <= op_n;
        rd_q      <= req_rd;
        off_q     <= align_off(sz_n, req_addr[1:0]);
        kill_q    <= 1'b0;
        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_we    <= req_we;
        mem_wstrb <= strb_of(sz_n, align_off(sz_n, req_addr[1:0]));
        mem_wdata <= lane_data(sz_n, req_wdata);
      end else if (flush && state != S_IDLE) begin
        // A killed store still writes; only the load writeback is dropped.
        kill_q <= 1'b1;
      end
      wb_valid <= rsp_fire & ~kill_q & ~flush;
      if (rsp_fire) begin
        wb_data <= ld_data;
        wb_rd   <= rd_q;
      end
    end
  end

  lsu_load_align u_align (
    .rdata (mem_rdata),
    .op    (op_q),
    .off   (off_q),
    .data  (ld_data)
  );

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected memory requests and
// writebacks; a negedge monitor compares them whenever the DUT presents them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] misalign_addr;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mexp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wexp_t;

  mexp_t mq[$];
  wexp_t wq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle a request is presented it must match the queue head, which
  // also checks it stays stable while mem_req_ready is low.
  always @(negedge clk) begin
    if (mem_req_valid) begin
      if (mq.size() == 0) chk("mem_unexpected", 1, 0);
      else begin
        chk("mem_addr", mem_addr, mq[0].addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
        if (mq[0].we) begin
          chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, mq[0].strb});
          chk("mem_wdata", mem_wdata, mq[0].wdata);
        end
        if (mem_req_ready) void'(mq.pop_front());
      end
    end
    if (wb_valid) begin
      if (wq.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, wq[0].rd});
        chk("wb_data", wb_data, wq[0].data);
        void'(wq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_we = we; req_op = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  // Full transaction; wb_exp is ignored for stores and when fl kills the load.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd,
                      input logic [31:0] e_addr, input logic [3:0] e_strb,
                      input logic [31:0] e_wd, input logic [31:0] rdata,
                      input logic [31:0] wb_exp, input int rwait, input int swait,
                      input bit fl);
    mexp_t m;
    wexp_t w;
    m.addr = e_addr; m.we = we; m.strb = e_strb; m.wdata = e_wd;
    mq.push_back(m);
    if (!we && !fl) begin w.rd = rd; w.data = wb_exp; wq.push_back(w); end
    issue(we, f3, addr, wd, rd);
    chk("req_ready_in_req", {31'd0, req_ready}, 0);
    chk("mem_req_valid_c1", {31'd0, mem_req_valid}, 1);
    for (int i = 0; i < rwait; i++) tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if (we) begin
      chk("req_ready_after_store", {31'd0, req_ready}, 1);
    end else begin
      chk("req_ready_in_resp", {31'd0, req_ready}, 0);
      for (int i = 0; i < swait; i++) begin
        flush = fl && (i == 0);
        tick();
        flush = 1'b0;
      end
      mem_rdata = rdata;
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      chk("wb_valid_latency", {31'd0, wb_valid}, {31'd0, !fl});
      chk("req_ready_after_load", {31'd0, req_ready}, 1);
      tick();
      chk("wb_valid_one_cycle", {31'd0, wb_valid}, 0);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", {31'd0, req_ready}, 1);

    // Stores
    xact(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    xact(1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    xact(1, 3'b001, 32'h102, 32'h1234BEEF, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 0, 0, 0, 0);
    xact(1, 3'b000, 32'h101, 32'h0000003C, 0, 32'h100, 4'b0010, 32'h3C3C3C3C, 0, 0, 0, 0, 0);

    // Loads, zero-wait memory
    xact(0, 3'b000, 32'h102, 0, 7, 32'h100, 0, 0, 32'h1280FF00, 32'hFFFFFF80, 0, 0, 0);
    xact(0, 3'b100, 32'h102, 0, 7, 32'h100, 0, 0, 32'h1280FF00, 32'h00000080, 0, 0, 0);
    xact(0, 3'b101, 32'h102, 0, 3, 32'h100, 0, 0, 32'h1280FF00, 32'h00001280, 0, 0, 0);
    xact(0, 3'b001, 32'h100, 0, 4, 32'h100, 0, 0, 32'h1280FF00, 32'hFFFFFF00, 0, 0, 0);
    xact(0, 3'b000, 32'h10C, 0, 9, 32'h10C, 0, 0, 32'h1280FF7F, 32'h0000007F, 0, 0, 0);

    // LW with 3 cycles of backpressure and a 2-cycle response delay
    xact(0, 3'b010, 32'h104, 0, 12, 32'h104, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 3, 2, 0);

    // LW flushed in RESP, then a normal SW
    xact(0, 3'b010, 32'h108, 0, 5, 32'h108, 0, 0, 32'h11111111, 0, 0, 1, 1);
    xact(1, 3'b010, 32'h200, 32'h01234567, 0, 32'h200, 4'b1111, 32'h01234567, 0, 0, 0, 0, 0);

    // Reset while a load waits for its response: late response is ignored
    begin
      mexp_t m;
      m.addr = 32'h300; m.we = 1'b0; m.strb = 0; m.wdata = 0;
      mq.push_back(m);
      issue(0, 3'b010, 32'h300, 0, 6);
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      mem_rdata = 32'h55555555; mem_rsp_valid = 1'b1; tick(); mem_rsp_valid = 1'b0;
      chk("rst_mid_no_wb", {31'd0, wb_valid}, 0);
      chk("rst_mid_idle", {31'd0, req_ready}, 1);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 3'b001, 32'h201, 0, 8);
    chk("trap_misalign", {31'd0, misalign}, 1);
    chk("trap_addr", misalign_addr, 32'h201);
    chk("trap_no_mem", {31'd0, mem_req_valid}, 0);
    chk("trap_idle", {31'd0, req_ready}, 1);
    tick();
    chk("trap_pulse", {31'd0, misalign}, 0);
    chk("trap_no_wb", {31'd0, wb_valid}, 0);
`else
    xact(0, 3'b001, 32'h201, 0, 8, 32'h200, 0, 0, 32'h1234F678, 32'hFFFFF678, 0, 0, 0);
    chk("no_trap_misalign", {31'd0, misalign}, 0);
    xact(0, 3'b010, 32'h207, 0, 2, 32'h204, 0, 0, 32'h89ABCDEF, 32'h89ABCDEF, 0, 0, 0);
`endif

    repeat (3) tick();
    chk("mem_queue_drained", mq.size(), 0);
    chk("wb_queue_drained", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
